add_mc: RTL and testbench

ADD_MC -- requirements
Module: add_mc

---
 rtl/add_mc_pkg.sv | 15 +
 rtl/add_mc_if.sv | 28 ++
 rtl/add_chunk.sv | 28 ++
 rtl/add_mc.sv | 179 +++++++++++++++++
 tb/tb_add_mc.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/add_mc_pkg.sv
// Shared types and default sizing for the multi-cycle chunked adder.
package add_mc_pkg;

    // Default operand width and the slice added on each clock
    localparam int ADD_MC_WIDTH = 32;
    localparam int ADD_MC_CHUNK = 4;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_mc_state_e;

endpackage

// File: rtl/add_mc_if.sv
// Operand/result handshake bundle for add_mc.
// The master side supplies operands and consumes results; the slave side is the adder.
interface add_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, flush, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, flush, out_ready,
        output in_ready, out_valid, sum, c_out, ovf, zero
    );
endinterface

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple adder slice. Also exposes the carry into the
// top bit of the slice so the caller can derive signed overflow.
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             c_o,
    output logic             c_msb_o
);
    logic [CHUNK:0] carry_s;

    // Bit-serial ripple through the slice
    always_comb begin
        carry_s    = '0;
        sum_o      = '0;
        carry_s[0] = c_i;
        for (int i = 0; i < CHUNK; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry_s[i];
            carry_s[i+1] = (a_i[i] & b_i[i]) | (carry_s[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign c_o     = carry_s[CHUNK];
    assign c_msb_o = carry_s[CHUNK-1];
endmodule

// File: rtl/add_mc.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock using one shared
// ripple slice, taking WIDTH/CHUNK cycles per operation.
// Optional macro ADD_MC_FLAGS_EN enables the ovf and zero flags; without it
// both outputs are tied low and their logic is absent.
module add_mc
    import add_mc_pkg::*;
#(
    parameter int WIDTH = ADD_MC_WIDTH,
    parameter int CHUNK = ADD_MC_CHUNK
) (
    input  logic   clk,
    input  logic   rst_n,
    add_mc_if.slave bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_RUN  = 2'(RUN);
    localparam logic [1:0] S_DONE = 2'(DONE);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("add_mc: WIDTH must be a multiple of CHUNK");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;

    logic [CHUNK-1:0] ch_a_s, ch_b_s, ch_sum_s;
    logic             ch_c_s, ch_msb_s;

    // Select the current slice of both operands
    always_comb begin
        ch_a_s = a_q[int'(cnt_q) * CHUNK +: CHUNK];
        ch_b_s = b_q[int'(cnt_q) * CHUNK +: CHUNK];
    end

    add_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_i     (ch_a_s),
        .b_i     (ch_b_s),
        .c_i     (carry_q),
        .sum_o   (ch_sum_s),
        .c_o     (ch_c_s),
        .c_msb_o (ch_msb_s)
    );

`ifdef ADD_MC_FLAGS_EN
    logic ovf_q, ovf_d;
    logic zero_q, zero_d;
`else
    logic unused_ch_msb_s;
    assign unused_ch_msb_s = ch_msb_s;
`endif

    // Next-state and datapath update; flush overrides everything else
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
`ifdef ADD_MC_FLAGS_EN
        ovf_d   = ovf_q;
        zero_d  = zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    // Subtraction is A + ~B + 1: invert B, seed carry with 1
                    a_d     = bus.a;
                    b_d     = bus.b ^ {WIDTH{bus.sub}};
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    sum_d   = '0;
                    c_out_d = 1'b0;
`ifdef ADD_MC_FLAGS_EN
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
`endif
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d[int'(cnt_q) * CHUNK +: CHUNK] = ch_sum_s;
                carry_d = ch_c_s;
                if (cnt_q == CNT_LAST) begin
                    c_out_d = ch_c_s;
`ifdef ADD_MC_FLAGS_EN
                    ovf_d   = ch_c_s ^ ch_msb_s;
                    zero_d  = (sum_d == {WIDTH{1'b0}});
`endif
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            carry_d = 1'b0;
            sum_d   = '0;
            c_out_d = 1'b0;
`ifdef ADD_MC_FLAGS_EN
            ovf_d   = 1'b0;
            zero_d  = 1'b0;
`endif
        end else begin
            cnt_d = cnt_d;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
        end
    end

`ifdef ADD_MC_FLAGS_EN
    // Flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
`else
    assign bus.ovf  = 1'b0;
    assign bus.zero = 1'b0;
`endif

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
endmodule

// File: tb/tb_add_mc.sv
// Directed, table-driven bench for add_mc (32/4 instance plus a 32/32 instance).
module tb_add_mc;
    logic clk;
    logic rst_n;

    add_mc_if #(.WIDTH(32)) bus1 ();
    add_mc_if #(.WIDTH(32)) bus2 ();

    add_mc #(.WIDTH(32), .CHUNK(4))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    add_mc #(.WIDTH(32), .CHUNK(32)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    vec_t vecs [10];
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic fexp(input logic x);
`ifdef ADD_MC_FLAGS_EN
        return x;
`else
        return 1'b0 & x;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present operands for one edge; returns at the negedge after acceptance
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        @(negedge clk);
        bus1.a = a; bus1.b = b; bus1.sub = sub; bus1.in_valid = 1'b1;
        @(negedge clk);
        bus1.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus1.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_done(input string name);
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        chk({name, " in_ready after take"}, 32'(bus1.in_ready), 32'd1);
        chk({name, " out_valid after take"}, 32'(bus1.out_valid), 32'd0);
    endtask

    task automatic watch_no_valid(input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus1.out_valid) seen++;
        end
        chk({name, " spurious out_valid"}, 32'(seen), 32'd0);
    endtask

    initial begin
        int lat;
        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.sub = 1'b0;
        bus1.flush = 1'b0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.sub = 1'b0;
        bus2.flush = 1'b0; bus2.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst in_ready",  32'(bus1.in_ready),  32'd1);
        chk("rst out_valid", 32'(bus1.out_valid), 32'd0);
        chk("rst sum",       bus1.sum,            32'd0);
        chk("rst c_out",     32'(bus1.c_out),     32'd0);
        chk("rst ovf",       32'(bus1.ovf),       32'd0);
        chk("rst zero",      32'(bus1.zero),      32'd0);
        rst_n = 1'b1;

        // Table of directed vectors
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sub);
            wait_done(lat);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd8);
            chk($sformatf("vec%0d sum", i),  bus1.sum,          vecs[i].s);
            chk($sformatf("vec%0d c_out", i), 32'(bus1.c_out),  32'(vecs[i].c));
            chk($sformatf("vec%0d ovf", i),  32'(bus1.ovf),     32'(fexp(vecs[i].v)));
            chk($sformatf("vec%0d zero", i), 32'(bus1.zero),    32'(fexp(vecs[i].z)));
            release_done($sformatf("vec%0d", i));
        end

        // Hold in DONE with out_ready low while in_valid toggles
        start_op(32'h7FFFFFFF, 32'h00000001, 1'b0);
        wait_done(lat);
        for (int k = 0; k < 5; k++) begin
            bus1.in_valid = k[0];
            bus1.a = 32'hDEAD0000 + 32'(k);
            bus1.b = 32'h0000BEEF;
            @(negedge clk);
            chk($sformatf("hold%0d sum", k),       bus1.sum,           32'h80000000);
            chk($sformatf("hold%0d out_valid", k), 32'(bus1.out_valid), 32'd1);
            chk($sformatf("hold%0d in_ready", k),  32'(bus1.in_ready),  32'd0);
            chk($sformatf("hold%0d ovf", k),       32'(bus1.ovf),       32'(fexp(1'b1)));
        end
        // Take result with in_valid high: must not re-accept in the same cycle
        bus1.in_valid = 1'b1;
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        bus1.out_ready = 1'b0;
        chk("take in_ready",  32'(bus1.in_ready),  32'd1);
        chk("take out_valid", 32'(bus1.out_valid), 32'd0);
        watch_no_valid("after take");

        // Asynchronous reset after three chunks of RUN
        start_op(32'h11111111, 32'h11111111, 1'b0);
        repeat (3) @(negedge clk);
        chk("pre-reset partial sum", bus1.sum, 32'h00000222);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst sum",       bus1.sum,            32'd0);
        chk("async rst out_valid", 32'(bus1.out_valid), 32'd0);
        chk("async rst in_ready",  32'(bus1.in_ready),  32'd1);
        chk("async rst c_out",     32'(bus1.c_out),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_valid("after reset");
        start_op(32'h12345678, 32'h87654321, 1'b0);
        wait_done(lat);
        chk("post-reset latency", 32'(lat), 32'd8);
        chk("post-reset sum", bus1.sum, 32'h99999999);
        release_done("post-reset");

        // Synchronous flush after three chunks of RUN
        start_op(32'h11111111, 32'h11111111, 1'b0);
        repeat (3) @(negedge clk);
        bus1.flush = 1'b1;
        #1;
        chk("flush not async", bus1.sum, 32'h00000222);
        @(negedge clk);
        bus1.flush = 1'b0;
        chk("flush sum",       bus1.sum,            32'd0);
        chk("flush out_valid", 32'(bus1.out_valid), 32'd0);
        chk("flush in_ready",  32'(bus1.in_ready),  32'd1);
        watch_no_valid("after flush");

        // Flush beats in_valid in IDLE
        @(negedge clk);
        bus1.flush = 1'b1; bus1.in_valid = 1'b1;
        @(negedge clk);
        bus1.flush = 1'b0; bus1.in_valid = 1'b0;
        chk("flush+valid in_ready", 32'(bus1.in_ready), 32'd1);
        watch_no_valid("flush+valid");

        // Flush while holding a result in DONE
        start_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
        wait_done(lat);
        chk("done c_out before flush", 32'(bus1.c_out), 32'd1);
        bus1.flush = 1'b1;
        @(negedge clk);
        bus1.flush = 1'b0;
        chk("done flush out_valid", 32'(bus1.out_valid), 32'd0);
        chk("done flush c_out",     32'(bus1.c_out),     32'd0);
        chk("done flush zero",      32'(bus1.zero),      32'd0);
        start_op(32'h00000007, 32'h00000005, 1'b1);
        wait_done(lat);
        chk("post-flush sum", bus1.sum, 32'h00000002);
        chk("post-flush c_out", 32'(bus1.c_out), 32'd1);
        release_done("post-flush");

        // Single-chunk instance: latency 1
        @(negedge clk);
        bus2.a = 32'h80000000; bus2.b = 32'h80000000; bus2.sub = 1'b0; bus2.in_valid = 1'b1;
        @(negedge clk);
        bus2.in_valid = 1'b0;
        chk("n1 out_valid after accept", 32'(bus2.out_valid), 32'd0);
        @(negedge clk);
        chk("n1 out_valid",  32'(bus2.out_valid), 32'd1);
        chk("n1 sum",        bus2.sum,            32'd0);
        chk("n1 c_out",      32'(bus2.c_out),     32'd1);
        chk("n1 ovf",        32'(bus2.ovf),       32'(fexp(1'b1)));
        chk("n1 zero",       32'(bus2.zero),      32'(fexp(1'b1)));
        bus2.out_ready = 1'b1;
        @(negedge clk);
        bus2.out_ready = 1'b0;
        chk("n1 in_ready", 32'(bus2.in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
